div_10b5b_seq: RTL and testbench

//  Sequential restoring divider: the inverse of the team's 5x5 array multiplier.

---
 rtl/div_10b5b_seq.sv | 107 ++++++++++
 tb/tb_div_10b5b_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_10b5b_seq.sv
// Sequential restoring divider, DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Companion to the 5x5 array multiplier; start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | restoring iterations, MSB first
// ZDIV  | divisor was zero; one cycle to keep the zero-divide done latency at k+1
// DONE  | results valid, done=1; a start here is accepted as in IDLE
module div_10b5b_seq #(
  parameter int DW = 10,
  parameter int VW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, ZDIV, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dvd_sh;
  logic [VW-1:0] dvs;
  logic [VW-1:0] p;
  logic [DW-1:0] q;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          last;
  logic [VW:0]   trial;
  logic          ge;
  logic [VW-1:0] p_nx;
  logic [DW-1:0] q_nx;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(1));

  // Kept remainder is always below the divisor, so VW bits suffice and the
  // modular subtraction below is exact.
  assign trial = {p, dvd_sh[DW-1]};
  assign ge    = (trial >= {1'b0, dvs});
  assign p_nx  = trial[VW-1:0] - (ge ? dvs : '0);
  assign q_nx  = {q[DW-2:0], ge};

  assign busy = (state == CALC) || (state == ZDIV);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start)               state_nx = (divisor == '0) ? ZDIV : CALC;
        else if (state == DONE)  state_nx = IDLE;
      end
      CALC:    if (last) state_nx = DONE;
      ZDIV:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh    <= '0;
      dvs       <= '0;
      p         <= '0;
      q         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else if (accept) begin
      dvd_sh <= dividend;
      dvs    <= divisor;
      p      <= '0;
      q      <= '0;
      cnt    <= CW'(DW);
    end else if (state == CALC) begin
      dvd_sh <= {dvd_sh[DW-2:0], 1'b0};
      p      <= p_nx;
      q      <= q_nx;
      cnt    <= cnt - CW'(1);
      if (last) begin
        quotient  <= q_nx;
        remainder <= p_nx;
        dz        <= 1'b0;
      end
    end else if (state == ZDIV) begin
      quotient  <= '1;
      remainder <= '0;
      dz        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_10b5b_seq.sv
// Directed bench for div_10b5b_seq: latency, results, zero divide, ignored start,
// mid-operation reset, back-to-back starts and a random sweep against the invariant.
module tb_div_10b5b_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] dividend;
  logic [4:0] divisor;
  logic       busy, done, dz;
  logic [9:0] quotient;
  logic [4:0] remainder;

  int checks = 0;
  int errors = 0;

  div_10b5b_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz)
  );

  always #5 clk = ~clk;

  // Drive a request so it is taken on the next edge; return 1ns after that edge.
  task automatic issue(input logic [9:0] a, input logic [4:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 10'h2AA; divisor = 5'h15;
  endtask

  // Count edges until done is seen (bounded); also count cycles where busy was low.
  task automatic wait_done(output int lat, output int busy_low);
    lat = 0; busy_low = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_low++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    checks++;
    if ({busy, done, quotient, remainder, dz} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {busy, done, quotient, remainder, dz});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [9:0] t_a [5] = '{10'd1000, 10'd961, 10'd1023, 10'd5, 10'd0};
    logic [4:0] t_b [5] = '{5'd7, 5'd31, 5'd1, 5'd9, 5'd17};
    logic [9:0] t_q [5] = '{10'd142, 10'd31, 10'd1023, 10'd0, 10'd0};
    logic [4:0] t_r [5] = '{5'd6, 5'd0, 5'd0, 5'd5, 5'd0};
    int lat, bl;
    for (int i = 0; i < 5; i++) begin
      issue(t_a[i], t_b[i]);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_accept[%0d] got %b want 1", i, busy); end
      wait_done(lat, bl);
      checks++;
      if (lat != 10) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 10", i, lat); end
      checks++;
      if (bl != 0) begin errors++; $display("FAIL basic_busy_low[%0d] got %0d cycles want 0", i, bl); end
      checks++;
      if ({quotient, remainder, dz} !== {t_q[i], t_r[i], 1'b0}) begin
        errors++;
        $display("FAIL basic_result[%0d] got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                 i, quotient, remainder, dz, t_q[i], t_r[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bl;
    issue(10'd200, 5'd0);
    wait_done(lat, bl);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++;
    if ({quotient, remainder, dz} !== {10'h3FF, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL dz_result got q=%h r=%0d dz=%b want q=3ff r=0 dz=1", quotient, remainder, dz);
    end
    issue(10'd200, 5'd3);
    wait_done(lat, bl);
    checks++;
    if (lat != 10 || {quotient, remainder, dz} !== {10'd66, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL dz_followup got lat=%0d q=%0d r=%0d dz=%b want lat=10 q=66 r=2 dz=0",
               lat, quotient, remainder, dz);
    end
  endtask

  task automatic test_start_ignored();
    int lat, bl, extra;
    issue(10'd1000, 5'd7);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 10'd50; divisor = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bl);
    checks++;
    if (lat + 5 != 10) begin errors++; $display("FAIL ignored_latency got %0d want 10", lat + 5); end
    checks++;
    if (bl != 0) begin errors++; $display("FAIL ignored_busy_low got %0d want 0", bl); end
    checks++;
    if ({quotient, remainder, dz} !== {10'd142, 5'd6, 1'b0}) begin
      errors++;
      $display("FAIL ignored_result got q=%0d r=%0d dz=%b want q=142 r=6 dz=0", quotient, remainder, dz);
    end
    extra = 0;
    repeat (15) begin @(posedge clk); #1; if (done) extra++; end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL ignored_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, bl, seen;
    issue(10'd1000, 5'd7);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, dz} !== 18'h0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0", {busy, done, quotient, remainder, dz});
    end
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_activity got %0d want 0", seen); end
    issue(10'd143, 5'd11);
    wait_done(lat, bl);
    checks++;
    if (lat != 10 || {quotient, remainder, dz} !== {10'd13, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_followup got lat=%0d q=%0d r=%0d dz=%b want lat=10 q=13 r=0 dz=0",
               lat, quotient, remainder, dz);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bl;
    issue(10'd77, 5'd4);
    wait_done(lat, bl);
    issue(10'd0, 5'd0);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept_in_done got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    wait_done(lat, bl);
    issue(10'd512, 5'd30);
    wait_done(lat, bl);
    checks++;
    if (lat != 10 || {quotient, remainder, dz} !== {10'd17, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result got lat=%0d q=%0d r=%0d dz=%b want lat=10 q=17 r=2 dz=0",
               lat, quotient, remainder, dz);
    end
  endtask

  task automatic test_sweep();
    int lat, bl;
    logic [9:0] a;
    logic [4:0] b;
    for (int i = 0; i < 12; i++) begin
      a = 10'($urandom_range(0, 1023));
      b = 5'($urandom_range(1, 31));
      issue(a, b);
      wait_done(lat, bl);
      checks++;
      if (lat != 10 || dz !== 1'b0 || remainder >= b ||
          (32'(quotient) * 32'(b) + 32'(remainder)) != 32'(a)) begin
        errors++;
        $display("FAIL sweep[%0d] %0d/%0d got lat=%0d q=%0d r=%0d dz=%b want q*d+r==%0d r<d lat=10",
                 i, a, b, lat, quotient, remainder, dz, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
